// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared types and helpers for the L2 round-robin lock arbiter.
// Holds the lock FSM state encoding, the round-robin pick function and an
// index-width helper.
package l2_arb_pkg;

    // Lock FSM states
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Upper bound on masters handled by rr_pick; the request vector is
    // zero-extended to this width before the scan.
    localparam int RR_MAX_MASTER = 64;
    localparam int RR_IDX_W      = 6;

    // Result of a round-robin scan
    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Width of an index able to address n items (at least one bit)
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of req scanning ptr, ptr+1, ... wrapping modulo n
    // (not modulo a power of two). idx is 0 when nothing is found.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_MASTER-1:0] req,
                                         input int ptr,
                                         input int n);
        rr_pick_t            res;
        int                  cand;
        logic [RR_IDX_W-1:0] cidx;
        res = '0;
        for (int i = 0; i < RR_MAX_MASTER; i++) begin
            if (i < n) begin
                cand = ptr + i;
                if (cand >= n) begin
                    cand = cand - n;
                end
                cidx = cand[RR_IDX_W-1:0];
                if (!res.found && req[cidx]) begin
                    res.found = 1'b1;
                    res.idx   = cidx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/l2_arb_out_slice.sv
// l2_arb_out_slice: one-entry valid/ready register slice placed between the
// arbiter and the bank port when L2_ARB_OUT_REG_EN is defined.
module l2_arb_out_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // The slice can take a new beat when empty or when it drains this cycle
    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Load on upstream handshake, otherwise drain on downstream grant
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/l2_rr_arb_lock.sv
// l2_rr_arb_lock: N-to-1 round-robin request arbiter for one L2 bank port,
// with bounded burst locking and a winner index reported to the response path.
// Optional macro L2_ARB_OUT_REG_EN inserts a one-entry output register slice
// (one extra cycle of latency); when undefined the path is fully combinational.
// N_MASTER may be any value from 2 up to l2_arb_pkg::RR_MAX_MASTER.
module l2_rr_arb_lock
    import l2_arb_pkg::*;
#(
    parameter  int N_MASTER   = 5,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int BE_WIDTH   = DATA_WIDTH / 8,
    parameter  int ID_WIDTH   = 8,
    parameter  int MAX_LOCK   = 16,
    localparam int LOG_MASTER = idx_width(N_MASTER)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER-1:0]            data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
    input  logic [N_MASTER-1:0]            data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
    input  logic [N_MASTER-1:0]            data_lock_i,
    output logic [N_MASTER-1:0]            data_gnt_o,
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          data_add_o,
    output logic                           data_wen_o,
    output logic [DATA_WIDTH-1:0]          data_wdata_o,
    output logic [BE_WIDTH-1:0]            data_be_o,
    output logic [ID_WIDTH-1:0]            data_ID_o,
    output logic [LOG_MASTER-1:0]          data_src_o,
    input  logic                           data_gnt_i
);

    // Lock counter spans 0..MAX_LOCK-1; one spare bit keeps MAX_LOCK=1 legal
    localparam int  CNT_W   = $clog2(MAX_LOCK + 1);
    // With MAX_LOCK=1 a lock would expire on the beat that set it
    localparam bit  LOCK_EN = (MAX_LOCK > 1);

    // Per-master payload unpacked from the flat input buses
    logic [ADDR_WIDTH-1:0] add_arr   [N_MASTER];
    logic [DATA_WIDTH-1:0] wdata_arr [N_MASTER];
    logic [BE_WIDTH-1:0]   be_arr    [N_MASTER];
    logic [ID_WIDTH-1:0]   id_arr    [N_MASTER];

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_unpack
            assign add_arr[gi]   = data_add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = data_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign be_arr[gi]    = data_be_i[gi*BE_WIDTH +: BE_WIDTH];
            assign id_arr[gi]    = data_ID_i[gi*ID_WIDTH +: ID_WIDTH];
        end
    endgenerate

    // Arbiter state
    lock_state_e           state_reg,      state_next;
    logic [LOG_MASTER-1:0] rr_ptr_reg,     rr_ptr_next;
    logic [LOG_MASTER-1:0] lock_owner_reg, lock_owner_next;
    logic [CNT_W-1:0]      lock_cnt_reg,   lock_cnt_next;

    // Selection
    logic [N_MASTER-1:0]      owner_mask;
    logic [N_MASTER-1:0]      eligible;
    logic [RR_MAX_MASTER-1:0] elig_wide;
    rr_pick_t                 pick;
    logic                     pick_unused;
    logic [LOG_MASTER-1:0]    winner;
    logic                     arb_req;
    logic                     arb_ready;
    logic                     arb_hs;

    // Winner payload
    logic [ADDR_WIDTH-1:0] win_add;
    logic                  win_wen;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [BE_WIDTH-1:0]   win_be;
    logic [ID_WIDTH-1:0]   win_id;

    // One-hot mask of the lock owner
    always_comb begin
        owner_mask                 = '0;
        owner_mask[lock_owner_reg] = 1'b1;
    end

    // While locked only the owner may compete, even when it is idle
    assign eligible  = (state_reg == LOCKED) ? (data_req_i & owner_mask) : data_req_i;
    assign elig_wide = RR_MAX_MASTER'(eligible);
    assign pick      = rr_pick(elig_wide, int'(rr_ptr_reg), N_MASTER);
    // Upper index bits are always zero; folded here so every bit is consumed
    assign pick_unused = ^pick;
    assign winner    = pick.idx[LOG_MASTER-1:0];
    assign arb_req   = pick.found;
    assign arb_hs    = arb_req && arb_ready;

    assign win_add   = add_arr[winner];
    assign win_wen   = data_wen_i[winner];
    assign win_wdata = wdata_arr[winner];
    assign win_be    = be_arr[winner];
    assign win_id    = id_arr[winner];

    // Grant goes only to the winner, and only on an arbiter-side handshake
    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_gnt
            assign data_gnt_o[gi] = arb_hs && (winner == LOG_MASTER'(gi));
        end
    endgenerate

    // Next pointer and lock FSM; everything holds without a handshake except
    // the abandon check, which only looks at the owner's request line
    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        lock_owner_next = lock_owner_reg;
        lock_cnt_next   = lock_cnt_reg;

        if (arb_hs) begin
            rr_ptr_next = (winner == LOG_MASTER'(N_MASTER - 1)) ? '0 : winner + 1'b1;
        end

        case (state_reg)
            UNLOCKED: begin
                if (LOCK_EN && arb_hs && data_lock_i[winner]) begin
                    state_next      = LOCKED;
                    lock_owner_next = winner;
                    lock_cnt_next   = CNT_W'(1);
                end
            end
            LOCKED: begin
                if (arb_hs) begin
                    if (data_lock_i[winner] && (lock_cnt_reg < CNT_W'(MAX_LOCK - 1))) begin
                        lock_cnt_next = lock_cnt_reg + 1'b1;
                    end else begin
                        // Owner released the lock or used its last beat
                        state_next    = UNLOCKED;
                        lock_cnt_next = '0;
                    end
                end else if (!data_req_i[lock_owner_reg]) begin
                    // Owner went idle: drop the lock so others are not starved
                    state_next    = UNLOCKED;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = UNLOCKED;
                lock_cnt_next = '0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= UNLOCKED;
            rr_ptr_reg     <= '0;
            lock_owner_reg <= '0;
            lock_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            lock_owner_reg <= lock_owner_next;
            lock_cnt_reg   <= lock_cnt_next;
        end
    end

`ifdef L2_ARB_OUT_REG_EN
    localparam int PAY_W = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH + ID_WIDTH + LOG_MASTER;

    logic [PAY_W-1:0] win_pay;
    logic [PAY_W-1:0] slice_pay;
    logic             slice_ready;

    assign win_pay   = {win_add, win_wen, win_wdata, win_be, win_id, winner};
    assign arb_ready = slice_ready;

    l2_arb_out_slice #(
        .WIDTH (PAY_W)
    ) u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (arb_req),
        .in_ready  (slice_ready),
        .in_data   (win_pay),
        .out_valid (data_req_o),
        .out_ready (data_gnt_i),
        .out_data  (slice_pay)
    );

    assign {data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_src_o} = slice_pay;
`else
    assign arb_ready    = data_gnt_i;
    assign data_req_o   = arb_req;
    assign data_add_o   = win_add;
    assign data_wen_o   = win_wen;
    assign data_wdata_o = win_wdata;
    assign data_be_o    = win_be;
    assign data_ID_o    = win_id;
    assign data_src_o   = winner;
`endif

endmodule

// File: tb/tb_l2_rr_arb_lock.sv
// tb_l2_rr_arb_lock: directed bench for l2_rr_arb_lock (combinational build).
// Two instances share all inputs: dut uses MAX_LOCK=16, dut4 uses MAX_LOCK=4.
module tb_l2_rr_arb_lock;

    localparam int N  = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 8;
    localparam int LW = 3;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]    data_req_i;
    logic [N*AW-1:0] data_add_i;
    logic [N-1:0]    data_wen_i;
    logic [N*DW-1:0] data_wdata_i;
    logic [N*BW-1:0] data_be_i;
    logic [N*IW-1:0] data_id_i;
    logic [N-1:0]    data_lock_i;
    logic            data_gnt_i;

    logic [N-1:0]  gnt_a,   gnt_b;
    logic          req_a,   req_b;
    logic [AW-1:0] add_a,   add_b;
    logic          wen_a,   wen_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic [BW-1:0] be_a,    be_b;
    logic [IW-1:0] id_a,    id_b;
    logic [LW-1:0] src_a,   src_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    l2_rr_arb_lock #(
        .N_MASTER (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ID_WIDTH (IW), .MAX_LOCK (16)
    ) dut (
        .clk (clk), .rst (rst),
        .data_req_i (data_req_i), .data_add_i (data_add_i), .data_wen_i (data_wen_i),
        .data_wdata_i (data_wdata_i), .data_be_i (data_be_i), .data_ID_i (data_id_i),
        .data_lock_i (data_lock_i), .data_gnt_o (gnt_a), .data_req_o (req_a),
        .data_add_o (add_a), .data_wen_o (wen_a), .data_wdata_o (wdata_a),
        .data_be_o (be_a), .data_ID_o (id_a), .data_src_o (src_a), .data_gnt_i (data_gnt_i)
    );

    l2_rr_arb_lock #(
        .N_MASTER (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ID_WIDTH (IW), .MAX_LOCK (4)
    ) dut4 (
        .clk (clk), .rst (rst),
        .data_req_i (data_req_i), .data_add_i (data_add_i), .data_wen_i (data_wen_i),
        .data_wdata_i (data_wdata_i), .data_be_i (data_be_i), .data_ID_i (data_id_i),
        .data_lock_i (data_lock_i), .data_gnt_o (gnt_b), .data_req_o (req_b),
        .data_add_o (add_b), .data_wen_o (wen_b), .data_wdata_o (wdata_b),
        .data_be_o (be_b), .data_ID_o (id_b), .data_src_o (src_b), .data_gnt_i (data_gnt_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one instance's outputs against a hand-given winner
    task automatic check_out(input string tag, input int which, input logic g,
                             input logic exp_req, input int exp_src);
        logic [N-1:0]  eg, og;
        logic          orq;
        logic [LW-1:0] os;
        logic [AW-1:0] oa, ea;
        logic [44:0]   om, em;
        logic [3:0]    ebe;
        logic [7:0]    eid;
        logic [31:0]   ewd;
        logic          ewen;
        int            s;
        s    = exp_src;
        eg   = (g && exp_req) ? (N'(1) << exp_src) : '0;
        ea   = 32'hA000_0000 + 32'(s * 16);
        ebe  = 4'(s + 1);
        eid  = 8'(8'h10 + s);
        ewd  = 32'hD000_0000 + 32'(s);
        ewen = s[0];
        em   = {ewen, ebe, eid, ewd};
        if (which == 1) begin
            og = gnt_b; orq = req_b; os = src_b; oa = add_b; om = {wen_b, be_b, id_b, wdata_b};
        end else begin
            og = gnt_a; orq = req_a; os = src_a; oa = add_a; om = {wen_a, be_a, id_a, wdata_a};
        end
        chk({tag, ".gnt"},  64'(og),  64'(eg));
        chk({tag, ".req"},  64'(orq), 64'(exp_req));
        chk({tag, ".src"},  64'(os),  64'(exp_src));
        chk({tag, ".addr"}, 64'(oa),  64'(ea));
        chk({tag, ".pay"},  64'(om),  64'(em));
        $display("%0t %s%s req_i=%b lock_i=%b gnt_i=%b -> gnt_o=%b src=%0d", $time, tag,
                 (which == 1) ? "/m4" : "", data_req_i, data_lock_i, g, og, os);
    endtask

    // Apply one cycle of stimulus; which: 0 = dut, 1 = dut4, 2 = both
    task automatic beat(input string tag, input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic g, input logic exp_req, input int exp_src, input int which);
        data_req_i  = r;
        data_lock_i = l;
        data_gnt_i  = g;
        @(negedge clk);
        if (which != 1) check_out(tag, 0, g, exp_req, exp_src);
        if (which != 0) check_out(tag, 1, g, exp_req, exp_src);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int m = 0; m < N; m++) begin
            data_add_i[m*AW +: AW]   = 32'hA000_0000 + 32'(m * 16);
            data_wdata_i[m*DW +: DW] = 32'hD000_0000 + 32'(m);
            data_be_i[m*BW +: BW]    = 4'(m + 1);
            data_id_i[m*IW +: IW]    = 8'(8'h10 + m);
            data_wen_i[m]            = m[0];
        end
        rst         = 1'b1;
        data_req_i  = '0;
        data_lock_i = '0;
        data_gnt_i  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: no request, master 0 payload, no grant
        beat("rst_idle", 5'b00000, 5'b00000, 1'b1, 1'b0, 0, 2);

        // Full rotation twice
        for (int i = 0; i < 10; i++) begin
            beat($sformatf("rr%0d", i), 5'b11111, 5'b00000, 1'b1, 1'b1, i % N, 2);
        end

        // Pointer at 4 wraps to 0 (no phantom indices 5..7), then 2
        beat("set_ptr4", 5'b01000, 5'b00000, 1'b1, 1'b1, 3, 2);
        beat("wrap0",    5'b00101, 5'b00000, 1'b1, 1'b1, 0, 2);
        beat("then2",    5'b00101, 5'b00000, 1'b1, 1'b1, 2, 2);

        // Lock by master 1 for three beats, released on the fourth, master 3 waiting
        beat("ptr1",      5'b00001, 5'b00000, 1'b1, 1'b1, 0, 2);
        beat("lock_b1",   5'b01010, 5'b00010, 1'b1, 1'b1, 1, 2);
        beat("lock_b2",   5'b01010, 5'b00010, 1'b1, 1'b1, 1, 2);
        beat("lock_b3",   5'b01010, 5'b00010, 1'b1, 1'b1, 1, 2);
        beat("lock_rel",  5'b01010, 5'b00000, 1'b1, 1'b1, 1, 2);
        beat("after_rel", 5'b01000, 5'b00000, 1'b1, 1'b1, 3, 2);

        // Abandoned lock: owner 2 idles, master 4 blocked for that cycle only
        beat("lk2",          5'b00100, 5'b00100, 1'b1, 1'b1, 2, 2);
        beat("abandon",      5'b10000, 5'b00000, 1'b1, 1'b0, 0, 2);
        beat("post_abandon", 5'b10000, 5'b00000, 1'b1, 1'b1, 4, 2);

        // Forced release after MAX_LOCK beats (dut4); dut keeps the lock
        beat("ptr2", 5'b00010, 5'b00000, 1'b1, 1'b1, 1, 2);
        for (int i = 0; i < 4; i++) begin
            beat($sformatf("force_b%0d", i + 1), 5'b00101, 5'b00100, 1'b1, 1'b1, 2, 2);
        end
        data_req_i  = 5'b00101;
        data_lock_i = 5'b00100;
        data_gnt_i  = 1'b1;
        @(negedge clk);
        check_out("force_b5", 1, 1'b1, 1'b1, 0);
        check_out("still_lk", 0, 1'b1, 1'b1, 2);
        @(posedge clk);
        #1;

        // Reset while dut is LOCKED: unlocked with pointer 0 afterwards
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat("post_rst", 5'b10101, 5'b00000, 1'b1, 1'b1, 0, 2);

        // Bank stall: no grants and no pointer movement
        beat("ptr2b", 5'b00010, 5'b00000, 1'b1, 1'b1, 1, 2);
        for (int i = 0; i < 5; i++) begin
            beat($sformatf("stall%0d", i), 5'b01010, 5'b00000, 1'b0, 1'b1, 3, 2);
        end
        beat("stall_done", 5'b01010, 5'b00000, 1'b1, 1'b1, 3, 2);
        beat("next_1",     5'b01010, 5'b00000, 1'b1, 1'b1, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
